// File: rtl/fft_stage_sequencer.sv
// Ping-pong FFT dataflow sequencer: one bit-reverse pass, then NUM_STAGES butterfly
// passes with alternating bank direction, behind an ap_start/ap_done/ap_continue handshake.
module fft_stage_sequencer #(
   parameter int NUM_STAGES = 10,
   parameter int STAGE_W    = 4,
   parameter int CNT_W      = 32
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic               ap_start,
   input  logic               ap_continue,
   output logic               ap_done,
   output logic               ap_idle,
   output logic               ap_ready,
   output logic               br_start,
   input  logic               br_done,
   output logic               br_continue,
   output logic               bf_start,
   input  logic               bf_done,
   output logic               bf_continue,
   output logic [STAGE_W-1:0] bf_stage,
   output logic               buf_sel,
   output logic               result_bank,
   output logic               busy,
   output logic [CNT_W-1:0]   last_cycles
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BR_RUN = 2'd1,
      S_BF_RUN = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;

   // The run-length counter sticks at all-ones instead of wrapping.
   assign w_cnt_inc   = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);
   assign result_bank = NUM_STAGES[0];

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         ap_idle     <= 1'b1;
         ap_done     <= 1'b0;
         ap_ready    <= 1'b0;
         busy        <= 1'b0;
         br_start    <= 1'b0;
         br_continue <= 1'b0;
         bf_start    <= 1'b0;
         bf_continue <= 1'b0;
         bf_stage    <= '0;
         buf_sel     <= 1'b0;
         last_cycles <= '0;
      end else begin
         ap_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ap_start) begin
                  r_state     <= S_BR_RUN;
                  r_cnt       <= '0;
                  ap_idle     <= 1'b0;
                  busy        <= 1'b1;
                  br_start    <= 1'b1;
                  br_continue <= 1'b1;
               end
            end
            S_BR_RUN: begin
               r_cnt <= w_cnt_inc;
               if (br_done) begin
                  r_state     <= S_BF_RUN;
                  br_start    <= 1'b0;
                  br_continue <= 1'b0;
                  bf_start    <= 1'b1;
                  bf_continue <= 1'b1;
                  bf_stage    <= '0;
                  buf_sel     <= 1'b0;
               end
            end
            S_BF_RUN: begin
               r_cnt <= w_cnt_inc;
               // bf_start stays high across stages so passes run back to back.
               if (bf_done) begin
                  if (bf_stage == LAST_STAGE) begin
                     r_state     <= S_DONE;
                     bf_start    <= 1'b0;
                     bf_continue <= 1'b0;
                     busy        <= 1'b0;
                     ap_done     <= 1'b1;
                     ap_ready    <= 1'b1;
                     last_cycles <= w_cnt_inc;
                  end else begin
                     bf_stage <= bf_stage + STAGE_W'(1);
                     buf_sel  <= ~buf_sel;
                  end
               end
            end
            S_DONE: begin
               if (ap_continue) begin
                  r_state <= S_IDLE;
                  ap_done <= 1'b0;
                  ap_idle <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               ap_idle     <= 1'b1;
               ap_done     <= 1'b0;
               busy        <= 1'b0;
               br_start    <= 1'b0;
               br_continue <= 1'b0;
               bf_start    <= 1'b0;
               bf_continue <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: a 10-stage and a 3-stage instance are exercised in turn
// with randomized child latencies, handshake timing, spurious done pulses and a mid-frame reset.
module tb_fft_stage_sequencer;

   logic ap_clk = 1'b0;
   logic ap_rst;
   logic sel;
   logic ap_start, ap_continue, inj_br, inj_bf;
   logic br_done, bf_done;

   logic done0, idle0, ready0, brs0, brc0, bfs0, bfc0, sel0, rb0, busy0;
   logic done1, idle1, ready1, brs1, brc1, bfs1, bfc1, sel1, rb1, busy1;
   logic [3:0]  stg0, stg1;
   logic [31:0] last0, last1;

   logic        c_done, c_idle, c_ready, c_brs, c_brc, c_bfs, c_bfc, c_sel, c_rb, c_busy;
   logic [3:0]  c_stg;
   logic [31:0] c_last;

   int br_cnt, bf_cnt, lbr, lbf, ns, k, t_done, t_end, pin, hold_stage, dly, rst_at, hold, aborted;
   int n_cmp, n_fail;
   logic [31:0] prev_last;

   int          x_stage;
   logic [31:0] x_last;
   logic        x_idle, x_done, x_ready, x_busy, x_brs, x_bfs;

   always #5 ap_clk = ~ap_clk;

   fft_stage_sequencer #(.NUM_STAGES(10), .STAGE_W(4), .CNT_W(32)) u_dut10 (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .ap_start(ap_start & ~sel), .ap_continue(ap_continue & ~sel),
      .ap_done(done0), .ap_idle(idle0), .ap_ready(ready0),
      .br_start(brs0), .br_done(br_done & ~sel), .br_continue(brc0),
      .bf_start(bfs0), .bf_done(bf_done & ~sel), .bf_continue(bfc0),
      .bf_stage(stg0), .buf_sel(sel0), .result_bank(rb0), .busy(busy0), .last_cycles(last0)
   );

   fft_stage_sequencer #(.NUM_STAGES(3), .STAGE_W(4), .CNT_W(32)) u_dut3 (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .ap_start(ap_start & sel), .ap_continue(ap_continue & sel),
      .ap_done(done1), .ap_idle(idle1), .ap_ready(ready1),
      .br_start(brs1), .br_done(br_done & sel), .br_continue(brc1),
      .bf_start(bfs1), .bf_done(bf_done & sel), .bf_continue(bfc1),
      .bf_stage(stg1), .buf_sel(sel1), .result_bank(rb1), .busy(busy1), .last_cycles(last1)
   );

   assign c_done  = sel ? done1  : done0;
   assign c_idle  = sel ? idle1  : idle0;
   assign c_ready = sel ? ready1 : ready0;
   assign c_brs   = sel ? brs1   : brs0;
   assign c_brc   = sel ? brc1   : brc0;
   assign c_bfs   = sel ? bfs1   : bfs0;
   assign c_bfc   = sel ? bfc1   : bfc0;
   assign c_sel   = sel ? sel1   : sel0;
   assign c_rb    = sel ? rb1    : rb0;
   assign c_busy  = sel ? busy1  : busy0;
   assign c_stg   = sel ? stg1   : stg0;
   assign c_last  = sel ? last1  : last0;

   // Child kernels: done pulses in the L-th cycle of start being high, plus injected noise.
   assign br_done = (c_brs && br_cnt == lbr - 1) || inj_br;
   assign bf_done = (c_bfs && bf_cnt == lbf - 1) || inj_bf;

   always @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         br_cnt <= 0;
         bf_cnt <= 0;
      end else begin
         br_cnt <= (c_brs && br_cnt != lbr - 1) ? br_cnt + 1 : 0;
         bf_cnt <= (c_bfs && bf_cnt != lbf - 1) ? bf_cnt + 1 : 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (stages=%0d cycle=%0d): got %0d, expected %0d", name, ns, k, act, exp);
      end
   endtask

   // Expected outputs follow from the frame timeline: k counts cycles after the accepting edge.
   always @(negedge ap_clk) begin
      if (k < 0) begin
         x_idle = 1'b1; x_done = 1'b0; x_ready = 1'b0; x_busy = 1'b0;
         x_brs = 1'b0; x_bfs = 1'b0; x_stage = hold_stage; x_last = prev_last;
      end else begin
         x_idle  = 1'b0;
         x_brs   = (k <= lbr);
         x_bfs   = (k > lbr) && (k < t_done);
         x_busy  = (k < t_done);
         x_done  = (k >= t_done);
         x_ready = (k == t_done);
         x_stage = x_bfs ? (k - lbr - 1) / lbf : ((k <= lbr) ? hold_stage : ns - 1);
         x_last  = (k >= t_done) ? 32'(lbr + ns * lbf) : prev_last;
      end
      chk("ap_idle", c_idle, x_idle);
      chk("ap_done", c_done, x_done);
      chk("ap_ready", c_ready, x_ready);
      chk("busy", c_busy, x_busy);
      chk("br_start", c_brs, x_brs);
      chk("br_continue", c_brc, x_brs);
      chk("bf_start", c_bfs, x_bfs);
      chk("bf_continue", c_bfc, x_bfs);
      chk("bf_stage", c_stg, 32'(x_stage));
      chk("buf_sel", c_sel, 32'(x_stage % 2));
      chk("last_cycles", c_last, x_last);
      chk("result_bank", c_rb, 32'(ns % 2));
      if (pin == 1 && k == 3)  chk("pin_br_start_c3", c_brs, 32'd1);
      if (pin == 1 && k == 4)  chk("pin_bf_start_c4", c_bfs, 32'd1);
      if (pin == 1 && k == 33) chk("pin_no_done_c33", c_done, 32'd0);
      if (pin == 1 && k == 34) begin
         chk("pin_done_c34", c_done, 32'd1);
         chk("pin_ready_c34", c_ready, 32'd1);
         chk("pin_last_33", c_last, 32'd33);
         chk("pin_bank_0", c_rb, 32'd0);
      end
      if (pin == 2 && k == 17) chk("pin_no_done_c17", c_done, 32'd0);
      if (pin == 2 && k == 18) begin
         chk("pin_done_c18", c_done, 32'd1);
         chk("pin_last_17", c_last, 32'd17);
         chk("pin_bank_1", c_rb, 32'd1);
      end
   end

   initial begin
      ap_rst = 1'b1; sel = 1'b0; ns = 10;
      ap_start = 1'b0; ap_continue = 1'b0; inj_br = 1'b0; inj_bf = 1'b0;
      k = -1; lbr = 1; lbf = 1; t_done = 0; t_end = 0; pin = 0;
      hold_stage = 0; prev_last = 32'd0; n_cmp = 0; n_fail = 0;
      dly = 0; rst_at = -1; hold = 0; aborted = 0;
      repeat (2) @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1); ns = (s == 1) ? 3 : 10;
         prev_last = 32'd0; hold_stage = 0;
         for (int f = 0; f < ((s == 1) ? 6 : 12); f++) begin
            hold = 0; rst_at = -1; pin = 0;
            lbr = $urandom_range(6, 1); lbf = $urandom_range(6, 1); dly = $urandom_range(4, 0);
            if (f == 0) begin
               lbr = (s == 1) ? 2 : 3; lbf = (s == 1) ? 5 : 3; dly = 0; pin = s + 1; hold = 1;
            end
            if (s == 0 && f == 1) begin dly = 20; hold = 1; end
            if (s == 0 && f == 2) rst_at = lbr + 5 * lbf + 1;
            if (f > 2) hold = $urandom_range(1, 0);
            t_done = 1 + lbr + ns * lbf; t_end = t_done + dly; aborted = 0;
            ap_start = 1'b1;
            @(posedge ap_clk); #1;
            k = 1;
            while (k <= t_end && aborted == 0) begin
               ap_start    = (hold != 0) ? 1'b1 : 1'($urandom_range(1, 0));
               ap_continue = (k >= t_done) ? (k == t_end) : 1'($urandom_range(1, 0));
               inj_br      = (k <= lbr) ? 1'b0 : ($urandom_range(3, 0) == 0);
               inj_bf      = (k > lbr && k < t_done) ? 1'b0 : ($urandom_range(3, 0) == 0);
               if (k == rst_at) begin
                  ap_rst = 1'b1; aborted = 1; k = -1;
                  prev_last = 32'd0; hold_stage = 0; pin = 0;
               end
               @(posedge ap_clk); #1;
               if (aborted == 0) k++;
            end
            if (aborted != 0) begin
               ap_rst = 1'b0;
            end else begin
               k = -1; prev_last = 32'(lbr + ns * lbf); hold_stage = ns - 1; pin = 0;
            end
            inj_br = 1'b0; inj_bf = 1'b0; ap_continue = 1'b0;
            ap_start = (hold != 0 && aborted == 0);
            if (!(hold != 0 && aborted == 0)) begin
               repeat ($urandom_range(3, 0)) begin
                  @(posedge ap_clk); #1;
               end
            end
         end
         ap_start = 1'b0;
         repeat (2) begin
            @(posedge ap_clk); #1;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
